// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM behind valid/ready request and response channels.
// Every access takes one access cycle plus WAIT_CYCLES wait states; misaligned or out-of-range
// addresses complete with rsp_err=1 and leave the RAM untouched.
// Optional feature: define DMEM_BYTE_STROBE_EN to add req_be[3:0] byte-enable masking for stores.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]        req_be,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic wr;
  logic [31:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0] be;
  logic [DATA_W-1:0] ram [2**ADDR_W];
  logic [ADDR_W-1:0] widx;
  logic err, commit, we;
  logic [31:0] mask;
  assign widx = addr[ADDR_W+1:2];
  assign err = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);
  assign commit = (state == WAIT) && (cnt == 4'd0);
  assign we = commit && wr && !err;
  assign mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
`ifndef DMEM_BYTE_STROBE_EN
  assign be = 4'hF;
`endif
  // Request/response FSM: latch at acceptance, count wait states, hold response until taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= 4'd0;
      wr        <= 1'b0;
      addr      <= 32'd0;
      wdata     <= '0;
`ifdef DMEM_BYTE_STROBE_EN
      be        <= 4'h0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          wr        <= req_write;
          addr      <= req_addr;
          wdata     <= req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
          be        <= req_be;
`endif
          cnt       <= 4'(WAIT_CYCLES);
          req_ready <= 1'b0;
          state     <= WAIT;
        end
        WAIT: if (cnt == 4'd0) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= err;
          rsp_rdata <= (err || wr) ? '0 : ram[widx];
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Store commit on the edge that enters RESP; only enabled bytes change.
  always_ff @(posedge clk) begin
    if (we) ram[widx] <= (ram[widx] & ~mask) | (wdata & mask);
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plus randomized checks of dmem_responder against a transaction-level model.
module tb_dmem_responder;
  localparam int W = 2;
`ifdef DMEM_BYTE_STROBE_EN
  localparam logic [3:0] BE_OR = 4'h0;
`else
  localparam logic [3:0] BE_OR = 4'hF;
`endif
  logic clk = 0, reset = 0;
  logic req_valid = 0, req_write = 0, rsp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_be = 4'hF;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int tests = 0, fails = 0;

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be(req_be),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %08h want %08h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Reference model: one outstanding transaction, response due 1+W edges after acceptance.
  logic [31:0] mem [256];
  logic busy = 0;
  int age = 0;
  logic m_wr = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  logic [3:0] m_be = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) busy <= 0;
    else if (!busy) begin
      if (req_valid) begin
        busy <= 1; age <= 0; m_wr <= req_write; m_addr <= req_addr;
        m_wdata <= req_wdata; m_be <= req_be | BE_OR;
      end
    end else begin
      age <= age + 1;
      if (age == W) begin
        m_rdata <= (bad(m_addr) || m_wr) ? 32'd0 : mem[m_addr[9:2]];
        if (m_wr && !bad(m_addr)) mem[m_addr[9:2]] <= merge(mem[m_addr[9:2]], m_wdata, m_be);
      end else if (age > W && rsp_ready) busy <= 0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (reset) begin
      automatic logic ev = busy && (age > W);
      check("req_ready", {31'd0, req_ready}, {31'd0, !busy});
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
      check("rsp_rdata", rsp_rdata, ev ? m_rdata : 32'd0);
      check("rsp_err", {31'd0, rsp_err}, {31'd0, ev && bad(m_addr)});
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                        input int hold, output logic [31:0] rd, output logic er, output int lat);
    int k = 0;
    rd = 0; er = 0; lat = -1;
    while (!req_ready && k < 100) begin @(negedge clk); k++; end
    if (!req_ready) begin check("req_ready_timeout", 0, 1); return; end
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_be = b;
    @(negedge clk);
    req_valid = 0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 64) begin rsp_ready = 1'($urandom); @(negedge clk); lat++; end
    if (!rsp_valid) begin check("rsp_valid_timeout", 0, 1); rsp_ready = 0; return; end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid}, 1);
      check("hold_ready", {31'd0, req_ready}, 0);
      check("hold_rdata", rsp_rdata, rd);
      check("hold_err", {31'd0, rsp_err}, {31'd0, er});
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("valid_drop", {31'd0, rsp_valid}, 0);
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int lat;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", {31'd0, rsp_err}, 0);
    reset = 1;
    @(negedge clk);
    do_req(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    check("st_lat", lat, W + 1);
    check("st_err", {31'd0, er}, 0);
    check("st_rdata", rd, 0);
    do_req(0, 32'h10, 0, 4'hF, 0, rd, er, lat);
    check("ld_rdata", rd, 32'hDEADBEEF);
    do_req(0, 32'h12, 0, 4'hF, 0, rd, er, lat);
    check("mis_err", {31'd0, er}, 1);
    check("mis_rdata", rd, 0);
    check("mis_lat", lat, W + 1);
    do_req(0, 32'h10, 0, 4'hF, 0, rd, er, lat);
    check("mis_word4", rd, 32'hDEADBEEF);
    do_req(1, 32'h0, 32'h0BADF00D, 4'hF, 0, rd, er, lat);
    do_req(0, 32'h400, 0, 4'hF, 0, rd, er, lat);
    check("oor_ld_err", {31'd0, er}, 1);
    do_req(1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
    check("oor_st_err", {31'd0, er}, 1);
    do_req(0, 32'h0, 0, 4'hF, 0, rd, er, lat);
    check("oor_alias", rd, 32'h0BADF00D);
    do_req(0, 32'h10, 0, 4'hF, 5, rd, er, lat);
    check("bp_rdata", rd, 32'hDEADBEEF);
    do_req(1, 32'h20, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
    // Store abandoned by reset while waiting.
    req_valid = 1; req_write = 1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    @(negedge clk);
    req_valid = 0;
    #2 reset = 0;
    #1;
    check("ar_req_ready", {31'd0, req_ready}, 1);
    check("ar_rsp_valid", {31'd0, rsp_valid}, 0);
    check("ar_rsp_rdata", rsp_rdata, 0);
    check("ar_rsp_err", {31'd0, rsp_err}, 0);
    repeat (3) @(negedge clk);
    reset = 1;
    repeat (4) @(negedge clk);
    check("ar_no_rsp", {31'd0, rsp_valid}, 0);
    do_req(0, 32'h20, 0, 4'hF, 0, rd, er, lat);
    check("ar_old_value", rd, 32'hCAFEF00D);
`ifdef DMEM_BYTE_STROBE_EN
    do_req(1, 32'h30, 32'hAABBCCDD, 4'hF, 0, rd, er, lat);
    do_req(1, 32'h30, 32'h11223344, 4'b0101, 0, rd, er, lat);
    do_req(0, 32'h30, 0, 4'hF, 0, rd, er, lat);
    check("be_merge", rd, 32'hAA22CC44);
    do_req(1, 32'h30, 32'h55555555, 4'b0000, 0, rd, er, lat);
    check("be_zero_err", {31'd0, er}, 0);
    do_req(0, 32'h30, 0, 4'hF, 0, rd, er, lat);
    check("be_zero_keep", rd, 32'hAA22CC44);
`endif
    for (int i = 0; i < 256; i++) do_req(1, 32'(i) << 2, $urandom, 4'hF, 0, rd, er, lat);
    for (int i = 0; i < 300; i++) begin
      automatic int sel = $urandom_range(0, 9);
      automatic logic [31:0] a = {22'd0, 8'($urandom), 2'b00};
      if (sel == 8) a[1:0] = 2'($urandom_range(1, 3));
      if (sel == 9) a = a | 32'h400 | ({$urandom} << 11);
      do_req(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), rd, er, lat);
      check("rnd_lat", lat, W + 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
